reg_dump_reader: RTL and testbench

Debug read-out engine for the integer register file. On a start pulse it walks the register file's asynchronous read port through addresses 0..NUM_REGS-1. It streams each value out on a valid/ready interface tagged with its index, for a debug/trace unit or testbench scoreboard. It is the reader counterpart to the core's writeback path. It shares read port 1 (A1/RD1) through an external mux selected by busy.

---
 rtl/reg_dump_reader_pkg.sv | 23 ++
 rtl/reg_dump_reader_out_stage.sv | 38 +++
 rtl/reg_dump_reader.sv | 152 +++++++++++++++
 tb/tb_reg_dump_reader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared types and sizes for the register-file debug dump reader.
// The DUMP_CHECKSUM_EN macro adds a trailing XOR checksum beat (CSUM state).
package rv_dbg_pkg;

    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        CSUM
    } dump_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } dump_state_t;
`endif

endpackage

// File: rtl/reg_dump_reader_out_stage.sv
// Single-entry valid/ready output register holding {data, idx, flags}.
// A load takes priority; otherwise an accepted beat empties the stage and clears its flags.
module dump_out_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 5,
    parameter int FLAG_W     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [IDX_WIDTH-1:0]  load_idx,
    input  logic [FLAG_W-1:0]     load_flags,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic [FLAG_W-1:0]     out_flags
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_flags <= '0;
        end else if (load_en) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_idx   <= load_idx;
            out_flags <= load_flags;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_flags <= '0;
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// Walks the register file read port over all indices and streams each value out with its index.
// Optional macro DUMP_CHECKSUM_EN appends an XOR checksum beat and the dump_is_csum port.
module reg_dump_reader
    import rv_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = REG_NUM,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic [ADDR_WIDTH-1:0] dump_idx,
    output logic                  dump_last
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic                  dump_is_csum
`endif
);

`ifdef DUMP_CHECKSUM_EN
    localparam int FLAG_W = 2;
`else
    localparam int FLAG_W = 1;
`endif
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    dump_state_t state, next_state;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  at_last;
    logic                  load_en;
    logic                  finish;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [ADDR_WIDTH-1:0] ld_idx;
    logic                  ld_last;
    logic [FLAG_W-1:0]     ld_flags;
    logic [FLAG_W-1:0]     out_flags;
`ifdef DUMP_CHECKSUM_EN
    logic                  ld_csum;
    logic [DATA_WIDTH-1:0] csum;
`endif

    assign at_last = (idx == LAST_IDX);
    assign rf_addr = idx;
    assign busy    = (state != IDLE);

    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        finish     = 1'b0;
        ld_data    = rf_data;
        ld_idx     = idx;
        ld_last    = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        ld_csum    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                load_en = !dump_valid || dump_ready;
`ifdef DUMP_CHECKSUM_EN
                if (load_en && at_last) next_state = CSUM;
`else
                ld_last = at_last;
                if (load_en && at_last) next_state = DRAIN;
`endif
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                // csum already folds the final register word loaded on the way in here
                load_en = !dump_valid || dump_ready;
                ld_data = csum;
                ld_idx  = '0;
                ld_last = 1'b1;
                ld_csum = 1'b1;
                if (load_en) next_state = DRAIN;
            end
`endif
            DRAIN: begin
                if (dump_valid && dump_ready && dump_last) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef DUMP_CHECKSUM_EN
    assign ld_flags     = {ld_csum, ld_last};
    assign dump_is_csum = out_flags[1];
`else
    assign ld_flags = ld_last;
`endif
    assign dump_last = out_flags[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            done  <= finish;
            if (state == IDLE && start) begin
                idx <= '0;
            end else if (state == RUN && load_en && !at_last) begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (state == IDLE && start) begin
            csum <= '0;
        end else if (state == RUN && load_en) begin
            csum <= csum ^ rf_data;
        end
    end
`endif

    dump_out_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_WIDTH (ADDR_WIDTH),
        .FLAG_W    (FLAG_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_data (ld_data),
        .load_idx  (ld_idx),
        .load_flags(ld_flags),
        .out_ready (dump_ready),
        .out_valid (dump_valid),
        .out_data  (dump_data),
        .out_idx   (dump_idx),
        .out_flags (out_flags)
    );

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: a register-file model feeds the DUT and expected beats are queued per dump.
// Build with DUMP_CHECKSUM_EN to exercise the checksum beat.
module tb_reg_dump_reader;

    localparam int NREG = 32;
`ifdef DUMP_CHECKSUM_EN
    localparam int DONE_LAT = 35;
`else
    localparam int DONE_LAT = 34;
`endif

    typedef struct packed {
        logic        csum;
        logic        last;
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [4:0]  dump_idx;
    logic        dump_last;
    logic        got_csum;

    logic [31:0] rf [NREG];
    beat_t       exp_q [$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    int          dones_seen = 0;
    int          dones_expected = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rf_data = (rf_addr == 5'd0) ? 32'h0 : rf[rf_addr];

    reg_dump_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .dump_idx    (dump_idx),
        .dump_last   (dump_last)
`ifdef DUMP_CHECKSUM_EN
        ,
        .dump_is_csum(got_csum)
`endif
    );

`ifndef DUMP_CHECKSUM_EN
    assign got_csum = 1'b0;
`endif

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: a dump is the register file as read index by index, plus an optional XOR beat.
    function automatic void push_dump();
        logic [31:0] x;
        logic [31:0] v;
        beat_t       b;
        x = 32'h0;
        for (int i = 0; i < NREG; i++) begin
            v = (i == 0) ? 32'h0 : rf[i];
            x = x ^ v;
            b.csum = 1'b0;
`ifdef DUMP_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == NREG - 1);
`endif
            b.idx  = 5'(i);
            b.data = v;
            exp_q.push_back(b);
        end
`ifdef DUMP_CHECKSUM_EN
        b.csum = 1'b1;
        b.last = 1'b1;
        b.idx  = 5'd0;
        b.data = x;
        exp_q.push_back(b);
`endif
        dones_expected++;
    endfunction

    // Core write landing before index k is read: the pending beat and the checksum both see it.
    function automatic void model_write(input int k, input logic [31:0] val);
        logic [31:0] old;
        old = rf[k];
        rf[k] = val;
        foreach (exp_q[j]) begin
            if (!exp_q[j].csum && exp_q[j].idx == 5'(k)) exp_q[j].data = val;
            if (exp_q[j].csum) exp_q[j].data = exp_q[j].data ^ old ^ val;
        end
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       dump_ready = 1'b1;
            1:       dump_ready = !dump_ready;
            default: dump_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops one expected beat per handshake and checks stall stability.
    beat_t       got_b;
    beat_t       exp_b;
    beat_t       held_b;
    logic [4:0]  held_addr;
    logic        prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            got_b = '{csum: got_csum, last: dump_last, idx: dump_idx, data: dump_data};
            if (prev_stall) begin
                check_output("stall_hold", {dump_valid, got_b, rf_addr}, {1'b1, held_b, held_addr});
            end
            if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_beat", 64'(got_b), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_b = exp_q.pop_front();
                    check_output("beat", 64'(got_b), 64'(exp_b));
                end
            end
            prev_stall = dump_valid && !dump_ready;
            held_b     = got_b;
            held_addr  = rf_addr;
            if (done) dones_seen++;
        end
    end

    task automatic apply_stimulus(input bit do_push);
        start = 1'b1;
        if (do_push) push_dump();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int at_cyc);
        int n;
        for (n = 0; n < 400; n++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        if (n == 400) check_output("done_timeout", 64'd0, 64'd1);
        at_cyc = cyc;
    endtask

    task automatic wait_beat(input logic [4:0] k);
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (dump_valid && dump_ready && dump_idx == k && !got_csum) break;
        end
        if (n == 400) check_output("beat_timeout", 64'd0, 64'(k));
    endtask

    initial begin
        int t0;
        int tdone;
        int n;
        rst = 1'b1;
        start = 1'b0;
        dump_ready = 1'b1;
        for (int i = 0; i < NREG; i++) rf[i] = 32'hA000_0000 + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_valid", 64'(dump_valid), 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_done", 64'(done), 64'd0);
        check_output("reset_addr", 64'(rf_addr), 64'd0);
        check_output("reset_payload", {dump_data, dump_idx, dump_last}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full dump with ready held high: latency and done timing
        t0 = cyc;
        apply_stimulus(1'b1);
        check_output("busy_after_start", 64'(busy), 64'd1);
        for (n = 0; n < 10 && !dump_valid; n++) begin
            @(posedge clk);
            #1;
        end
        check_output("first_beat_latency", 64'(cyc - t0), 64'd2);
        wait_done(tdone);
        check_output("done_latency", 64'(tdone - t0), 64'(DONE_LAT));
        check_output("busy_in_done_cycle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check_output("done_one_cycle", 64'(done), 64'd0);

        // Alternating ready exercises stall stability
        ready_mode = 1;
        apply_stimulus(1'b1);
        wait_done(tdone);
        @(posedge clk);
        #1;

        // Random register contents with random backpressure
        ready_mode = 2;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NREG; i++) rf[i] = $urandom;
            apply_stimulus(1'b1);
            wait_done(tdone);
            @(posedge clk);
            #1;
        end

        // Starts during a dump are ignored; a start in the done cycle launches a new dump
        ready_mode = 0;
        apply_stimulus(1'b1);
        for (int i = 0; i < 20; i++) begin
            start = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done(tdone);
        apply_stimulus(1'b1);
        check_output("restart_from_done", 64'(busy), 64'd1);
        wait_done(tdone);
        @(posedge clk);
        #1;

        // Reset mid-dump abandons the stream without a done pulse
        apply_stimulus(1'b1);
        wait_beat(5'd10);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("rst_valid", 64'(dump_valid), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        dones_expected--;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply_stimulus(1'b1);
        wait_done(tdone);
        @(posedge clk);
        #1;

        // A write to a register not yet read shows up in the stream
        for (int i = 0; i < NREG; i++) rf[i] = 32'hA000_0000 + 32'(i);
        ready_mode = 2;
        apply_stimulus(1'b1);
        wait_beat(5'd5);
        model_write(20, 32'hDEAD_BEEF);
        wait_done(tdone);
        @(posedge clk);
        #1;

`ifdef DUMP_CHECKSUM_EN
        ready_mode = 0;
        for (int i = 0; i < NREG; i++) rf[i] = 32'(i);
        apply_stimulus(1'b1);
        wait_done(tdone);
        @(posedge clk);
        #1;
        rf[3] = 32'hFF;
        apply_stimulus(1'b1);
        wait_done(tdone);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        check_output("queue_drained", 64'(exp_q.size()), 64'd0);
        check_output("done_count", 64'(dones_seen), 64'(dones_expected));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
